// File: rtl/comparator_if.sv
// Operand/result bundle for the registered comparator.
// abs_diff exists only when COMPARATOR_DIFF_EN is defined.
interface comparator_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             signed_mode;
  logic             in_valid;
  logic             A_is_greater;
  logic             B_is_greater;
  logic             are_equal;
  logic             out_valid;
`ifdef COMPARATOR_DIFF_EN
  logic [WIDTH-1:0] abs_diff;
`endif

  modport master (
    output A, B, signed_mode, in_valid,
`ifdef COMPARATOR_DIFF_EN
    input  abs_diff,
`endif
    input  A_is_greater, B_is_greater, are_equal, out_valid
  );

  modport slave (
    input  A, B, signed_mode, in_valid,
`ifdef COMPARATOR_DIFF_EN
    output abs_diff,
`endif
    output A_is_greater, B_is_greater, are_equal, out_valid
  );
endinterface

// File: rtl/comparator.sv
// Registered magnitude comparator, unsigned or two's complement per sample.
// Optional registered |A-B| output when COMPARATOR_DIFF_EN is defined.
module comparator #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  comparator_if.slave  bus
);

  logic [WIDTH:0] a_ext, b_ext;
  logic           gt, lt, eq;

  logic gt_q, gt_d;
  logic lt_q, lt_d;
  logic eq_q, eq_d;
  logic valid_q, valid_d;

  // One extra bit lets a single signed compare cover both modes:
  // sign-extend in signed mode, zero-extend otherwise.
  always_comb begin
    a_ext = {bus.signed_mode & bus.A[WIDTH-1], bus.A};
    b_ext = {bus.signed_mode & bus.B[WIDTH-1], bus.B};
    gt    = $signed(a_ext) > $signed(b_ext);
    lt    = $signed(a_ext) < $signed(b_ext);
    eq    = (bus.A == bus.B);
  end

  always_comb begin
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    valid_d = bus.in_valid;
    if (bus.in_valid) begin
      gt_d = gt;
      lt_d = lt;
      eq_d = eq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      valid_q <= valid_d;
    end
  end

  assign bus.A_is_greater = gt_q;
  assign bus.B_is_greater = lt_q;
  assign bus.are_equal    = eq_q;
  assign bus.out_valid    = valid_q;

`ifdef COMPARATOR_DIFF_EN
  logic [WIDTH-1:0] diff_q, diff_d;

  // Truncated WIDTH-bit subtraction equals the low bits of the WIDTH+1 result.
  always_comb begin
    diff_d = diff_q;
    if (bus.in_valid) begin
      diff_d = lt ? (bus.B - bus.A) : (bus.A - bus.B);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q <= '0;
    end else begin
      diff_q <= diff_d;
    end
  end

  assign bus.abs_diff = diff_q;
`endif

endmodule

// File: tb/tb_comparator.sv
// Self-checking bench for comparator: directed cases, reset behaviour and random samples
// against an integer reference model. Define COMPARATOR_DIFF_EN to also check abs_diff.
module tb_comparator;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic           exp_gt, exp_lt, exp_eq, exp_ov;
  logic [W-1:0]   exp_diff;

  comparator_if #(.WIDTH(W)) bus ();

  comparator #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int to_int(input logic [W-1:0] x, input logic sm);
    int v;
    v = int'(x);
    if (sm && x[W-1]) v = v - (1 << W);
    return v;
  endfunction

  task automatic model_sample(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    int ia, ib, d;
    ia = to_int(a, sm);
    ib = to_int(b, sm);
    exp_gt = (ia > ib);
    exp_lt = (ia < ib);
    exp_eq = (a == b);
    d = (ia > ib) ? ia - ib : ib - ia;
    exp_diff = W'(d % (1 << W));
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".gt"},    {3'b0, bus.A_is_greater}, {3'b0, exp_gt});
    check({tag, ".lt"},    {3'b0, bus.B_is_greater}, {3'b0, exp_lt});
    check({tag, ".eq"},    {3'b0, bus.are_equal},    {3'b0, exp_eq});
    check({tag, ".valid"}, {3'b0, bus.out_valid},    {3'b0, exp_ov});
`ifdef COMPARATOR_DIFF_EN
    check({tag, ".diff"},  bus.abs_diff, exp_diff);
`endif
  endtask

  task automatic apply(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sm, input logic v);
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.signed_mode = sm;
    bus.in_valid = v;
    @(posedge clk);
    #1;
    if (v) model_sample(a, b, sm);
    exp_ov = v;
    check_outputs(tag);
    $display("txn %s A=%0h B=%0h sm=%0b v=%0b -> gt=%0b lt=%0b eq=%0b ov=%0b",
             tag, a, b, sm, v, bus.A_is_greater, bus.B_is_greater, bus.are_equal, bus.out_valid);
  endtask

  task automatic reset_model();
    exp_gt = 1'b0; exp_lt = 1'b0; exp_eq = 1'b0; exp_ov = 1'b0; exp_diff = '0;
  endtask

  // One-hot property whenever a result is presented.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid === 1'b1) begin
      check("onehot", {1'b0, bus.A_is_greater + bus.B_is_greater + bus.are_equal}, 4'd1);
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    reset_model();
    bus.A = '0;
    bus.B = '0;
    bus.signed_mode = 1'b0;
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_outputs("reset_async");
    @(negedge clk);
    rst_n = 1'b1;

    apply("u_gt",   4'b1000, 4'b0111, 1'b0, 1'b1);
    apply("u_lt",   4'b1000, 4'b1011, 1'b0, 1'b1);
    apply("u_eq",   4'b1010, 4'b1010, 1'b0, 1'b1);
    apply("s_lt",   4'b1000, 4'b0111, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) apply("hold", 4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
    apply("s_gt",   4'b0001, 4'b1111, 1'b1, 1'b1);
    apply("s_eq",   4'b1111, 4'b1111, 1'b1, 1'b1);

    // Reset asserted mid-cycle with a sample pending.
    @(negedge clk);
    bus.A = 4'h3; bus.B = 4'h9; bus.signed_mode = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    reset_model();
    #1 check_outputs("reset_mid");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 check_outputs("reset_held");
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    apply("reset_exit", 4'h5, 4'h2, 1'b0, 1'b0);
    apply("post_reset", 4'h5, 4'h2, 1'b0, 1'b1);

    for (int i = 0; i < 60; i++) begin
      apply("rand", 4'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
